// File: rtl/tx_arbiter.sv
// tx_arbiter: one-byte holding slot per requester, drained into a single UART transmitter.
// Define TX_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; default is round-robin.

module tx_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_busy,
  output logic [NREQ-1:0]          ovf,
  input  logic [NREQ-1:0]          ovf_clr,
  output logic                     tx_req,
  output logic [DW-1:0]            tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(NREQ)-1:0]  grant
);

  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitBusy, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, winner;
  logic [DW-1:0]   tx_data_q, tx_data_d;
  logic [1:0]      quiet_q, quiet_d;
  logic [NREQ-1:0] slot_valid_q, slot_valid_d;
  logic [NREQ-1:0] ovf_q, ovf_d;
  logic [NREQ-1:0] issue_clr, capture;
  logic [DW-1:0]   slot_q [NREQ];

  // A strobe into a full slot (including the one being issued) is dropped and flagged.
  assign capture      = req_valid & ~slot_valid_q;
  assign slot_valid_d = capture | (slot_valid_q & ~issue_clr);
  assign ovf_d        = ~ovf_clr & (ovf_q | (req_valid & slot_valid_q));

  always_comb begin
    winner = grant_q;
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (slot_valid_q[i]) winner = GW'(i);
    end
`else
    // Walk backwards so the nearest full slot after grant_q is the last one written.
    for (int k = NREQ; k >= 1; k--) begin
      if (slot_valid_q[(32'(grant_q) + 32'(k)) % NREQ]) begin
        winner = GW'((32'(grant_q) + 32'(k)) % NREQ);
      end
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    quiet_d   = quiet_q;
    issue_clr = '0;
    unique case (state_q)
      StIdle: begin
        if ((|slot_valid_q) && !tx_busy) begin
          grant_d   = winner;
          tx_data_d = slot_q[winner];
          state_d   = StIssue;
        end
      end
      StIssue: begin
        issue_clr[grant_q] = 1'b1;
        quiet_d            = 2'd0;
        state_d            = StWaitBusy;
      end
      StWaitBusy: begin
        // Give up after the pulse plus three quiet cycles; the byte is not retried.
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (quiet_q == 2'd2) begin
          state_d = StIdle;
        end else begin
          quiet_d = quiet_q + 2'd1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      grant_q      <= GW'(NREQ - 1);
      tx_data_q    <= '0;
      quiet_q      <= 2'd0;
      slot_valid_q <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      tx_data_q    <= tx_data_d;
      quiet_q      <= quiet_d;
      slot_valid_q <= slot_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (capture[i]) slot_q[i] <= req_data[i*DW +: DW];
      end
    end
  end

  assign req_busy = slot_valid_q;
  assign ovf      = ovf_q;
  assign tx_req   = (state_q == StIssue);
  assign tx_data  = tx_data_q;
  assign grant    = grant_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized + directed bench for tx_arbiter against a transaction-level reference model.
// The model tracks slot ownership and the send handshake; a simple transmitter model drives tx_busy.

module tb_tx_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned DW   = 8;

  logic                     clk;
  logic                     reset;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DW-1:0]       req_data;
  logic [NREQ-1:0]          req_busy;
  logic [NREQ-1:0]          ovf;
  logic [NREQ-1:0]          ovf_clr;
  logic                     tx_req;
  logic [DW-1:0]            tx_data;
  logic                     tx_busy;
  logic [$clog2(NREQ)-1:0]  grant;

  tx_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_busy  (req_busy),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .tx_req    (tx_req),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which slots hold a byte, and where the single send is in its handshake.
  // Phase 0 = free, 1 = pulse this cycle, 2 = awaiting transmitter busy, 3 = awaiting done.
  bit          m_full [NREQ];
  logic [DW-1:0] m_byte [NREQ];
  bit          m_ovf  [NREQ];
  int          m_grant;
  int          m_phase;
  int          m_quiet;
  logic [DW-1:0] m_txdata;

  // Transmitter model and observation log.
  int          tx_left, tx_len_fix, ign_pct, cyc;
  bit          hold_busy;
  logic [DW-1:0] sent [$];
  int          pulse_cyc [$];

  function automatic void model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_full[i] = 0;
      m_byte[i] = '0;
      m_ovf[i]  = 0;
    end
    m_grant  = NREQ - 1;
    m_phase  = 0;
    m_quiet  = 0;
    m_txdata = '0;
  endfunction

  function automatic int pick();
`ifdef TX_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (m_full[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (m_full[(m_grant + k) % NREQ]) return (m_grant + k) % NREQ;
`endif
    return m_grant;
  endfunction

  function automatic void model_step(input logic [NREQ-1:0] iv, input logic [NREQ*DW-1:0] d,
                                     input logic [NREQ-1:0] clr, input logic b);
    bit any;
    bit issuing;
    int issue_idx;
    int w;
    any       = 0;
    issuing   = (m_phase == 1);
    issue_idx = m_grant;
    for (int i = 0; i < NREQ; i++) any |= m_full[i];
    case (m_phase)
      0: if (any && !b) begin
        w        = pick();
        m_grant  = w;
        m_txdata = m_byte[w];
        m_phase  = 1;
      end
      1: begin
        m_phase = 2;
        m_quiet = 0;
      end
      2: if (b) m_phase = 3;
         else begin
           m_quiet++;
           if (m_quiet == 3) m_phase = 0;
         end
      default: if (!b) m_phase = 0;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      bit strobe_full;
      strobe_full = iv[i] && m_full[i];
      m_ovf[i] = clr[i] ? 1'b0 : (m_ovf[i] || strobe_full);
      if (iv[i] && !m_full[i]) begin
        m_full[i] = 1;
        m_byte[i] = d[i*DW +: DW];
      end else if (issuing && i == issue_idx) begin
        m_full[i] = 0;
      end
    end
  endfunction

  task automatic cycle(input logic [NREQ-1:0] iv, input logic [NREQ*DW-1:0] d,
                       input logic [NREQ-1:0] clr);
    logic [NREQ-1:0] exp_busy, exp_ovf;
    logic b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      exp_busy[i] = m_full[i];
      exp_ovf[i]  = m_ovf[i];
    end
    check_eq("req_busy", 32'(req_busy), 32'(exp_busy));
    check_eq("ovf", 32'(ovf), 32'(exp_ovf));
    check_eq("tx_req", 32'(tx_req), 32'(m_phase == 1));
    check_eq("tx_data", 32'(tx_data), 32'(m_txdata));
    check_eq("grant", 32'(grant), 32'(m_grant));
    if (tx_req) begin
      sent.push_back(tx_data);
      pulse_cyc.push_back(cyc);
    end
    b = hold_busy || (tx_left > 0);
    if (tx_left > 0) tx_left--;
    if (tx_req && reset && ($urandom_range(0, 99) >= ign_pct)) begin
      tx_left = (tx_len_fix != 0) ? tx_len_fix : int'($urandom_range(1, 10));
    end
    req_valid = iv;
    req_data  = d;
    ovf_clr   = clr;
    tx_busy   = b;
    if (!reset) model_reset();
    else model_step(iv, d, clr, b);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle('0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    tx_left   = 0;
    hold_busy = 0;
    model_reset();
    repeat (n) cycle('1, '1, '0);
    cycle('0, '0, '0);
    reset = 1'b1;
  endtask

  int s, c;

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    ovf_clr    = '0;
    tx_busy    = 1'b0;
    tx_left    = 0;
    tx_len_fix = 0;
    ign_pct    = 0;
    hold_busy  = 0;
    cyc        = 0;
    model_reset();

    // Reset with strobes on every line.
    do_reset(3);
    check_eq("rst_grant", 32'(grant), NREQ - 1);
    check_eq("rst_busy", 32'(req_busy), 0);
    check_eq("rst_txreq", 32'(tx_req), 0);

    // Contention: round-robin starts at requester 0 after reset.
    s = sent.size();
    cycle(2'b11, 16'h2010, '0);
    idle(40);
    cycle(2'b11, 16'h2010, '0);
    idle(40);
    check_eq("cont_count", sent.size() - s, 4);
    if (sent.size() - s == 4) begin
      check_eq("cont_b0", 32'(sent[s]), 32'h10);
      check_eq("cont_b1", 32'(sent[s+1]), 32'h20);
      check_eq("cont_b2", 32'(sent[s+2]), 32'h10);
      check_eq("cont_b3", 32'(sent[s+3]), 32'h20);
    end

    // Single byte: tx_req exactly two cycles after the strobe.
    tx_len_fix = 10;
    s = sent.size();
    cycle(2'b01, 16'h0041, '0);
    c = cyc;
    idle(20);
    check_eq("single_count", sent.size() - s, 1);
    if (sent.size() - s == 1) begin
      check_eq("single_data", 32'(sent[s]), 32'h41);
      check_eq("single_lat", pulse_cyc[s] - c, 2);
    end

    // Overflow while transmitter busy, then clear, then clear vs. set in one cycle.
    hold_busy = 1;
    cycle(2'b10, 16'h5500, '0);
    cycle(2'b10, 16'h6600, '0);
    idle(1);
    check_eq("ovf_set", 32'(ovf), 32'b10);
    s = sent.size();
    hold_busy = 0;
    idle(20);
    check_eq("ovf_count", sent.size() - s, 1);
    if (sent.size() - s == 1) check_eq("ovf_data", 32'(sent[s]), 32'h55);
    cycle('0, '0, 2'b10);
    idle(1);
    check_eq("ovf_clr", 32'(ovf), 0);
    hold_busy = 1;
    cycle(2'b10, 16'h7700, '0);
    cycle(2'b10, 16'h7800, 2'b10);
    idle(1);
    check_eq("ovf_clr_wins", 32'(ovf), 0);
    hold_busy = 0;
    idle(20);

    // Timeout: transmitter ignores every pulse; sends are 5 cycles apart.
    ign_pct = 100;
    idle(5);
    s = sent.size();
    cycle(2'b11, 16'hBBAA, '0);
    idle(15);
    check_eq("tmo_count", sent.size() - s, 2);
    if (sent.size() - s == 2) check_eq("tmo_gap", pulse_cyc[s+1] - pulse_cyc[s], 5);

    // Randomized traffic.
    ign_pct    = 20;
    tx_len_fix = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [NREQ-1:0] iv, clr;
      for (int i = 0; i < NREQ; i++) begin
        iv[i]  = ($urandom_range(0, 99) < 25);
        clr[i] = ($urandom_range(0, 99) < 5);
      end
      cycle(iv, NREQ*DW'($urandom), clr);
    end

    // Mid-operation reset during WAIT_DONE with both slots full.
    ign_pct    = 0;
    tx_len_fix = 20;
    idle(25);
    s = sent.size();
    cycle(2'b11, 16'hB2A1, '0);
    idle(5);
    check_eq("midrst_pulse", sent.size() - s, 1);
    cycle(2'b11, 16'hD4C3, '0);
    idle(1);
    check_eq("midrst_full", 32'(req_busy), 32'b11);
    do_reset(2);
    s = sent.size();
    idle(30);
    check_eq("midrst_nosend", sent.size() - s, 0);
    check_eq("midrst_empty", 32'(req_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
